// File: rtl/traffic_timer_unit.sv
// traffic_timer_unit
//   Three independent interval timers (T60, T50, T10 seconds) for the two-road
//   traffic light controller. Each timer has its own sub-second prescaler and
//   its own seconds down-counter. The done flags are high while the counter
//   reads zero, and they stay high until that timer is restarted.
//
//   Optional build macro: TLC_REMAIN_OUT_EN
//     When defined, adds remain_sec, the seconds left on the timer that was
//     restarted most recently. It drives a countdown display.
//
//   Reset is asynchronous and active high. On reset every timer loads its full
//   interval, so timer 60 starts counting immediately without a strobe.

module traffic_timer_unit #(
  parameter int TICK_DIV = 50000000,
  parameter int T60      = 60,
  parameter int T50      = 50,
  parameter int T10      = 10,
  parameter int SEC_W    = 7,
  parameter int DIV_W    = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hold,
  input  logic             timer_reset_60,
  input  logic             timer_reset_50,
  input  logic             timer_reset_10,
`ifdef TLC_REMAIN_OUT_EN
  output logic [SEC_W-1:0] remain_sec,
`endif
  output logic             timer_done_60,
  output logic             timer_done_50,
  output logic             timer_done_10
);

  localparam logic [SEC_W-1:0] L_SEC_60  = SEC_W'(T60);
  localparam logic [SEC_W-1:0] L_SEC_50  = SEC_W'(T50);
  localparam logic [SEC_W-1:0] L_SEC_10  = SEC_W'(T10);
  localparam logic [DIV_W-1:0] L_SUB_TOP = DIV_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0] L_SEC_0   = '0;
  localparam logic [DIV_W-1:0] L_SUB_0   = '0;

  logic [SEC_W-1:0] r_sec_60, r_sec_50, r_sec_10;
  logic [DIV_W-1:0] r_sub_60, r_sub_50, r_sub_10;

  // Timer 60: restart wins over hold; an expired timer idles at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec_60 <= L_SEC_60;
      r_sub_60 <= L_SUB_TOP;
    end else if (timer_reset_60) begin
      r_sec_60 <= L_SEC_60;
      r_sub_60 <= L_SUB_TOP;
    end else if (!hold && r_sec_60 != L_SEC_0) begin
      if (r_sub_60 == L_SUB_0) begin
        r_sub_60 <= L_SUB_TOP;
        r_sec_60 <= r_sec_60 - 1'b1;
      end else begin
        r_sub_60 <= r_sub_60 - 1'b1;
      end
    end
  end

  // Timer 50: same countdown, with its own prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec_50 <= L_SEC_50;
      r_sub_50 <= L_SUB_TOP;
    end else if (timer_reset_50) begin
      r_sec_50 <= L_SEC_50;
      r_sub_50 <= L_SUB_TOP;
    end else if (!hold && r_sec_50 != L_SEC_0) begin
      if (r_sub_50 == L_SUB_0) begin
        r_sub_50 <= L_SUB_TOP;
        r_sec_50 <= r_sec_50 - 1'b1;
      end else begin
        r_sub_50 <= r_sub_50 - 1'b1;
      end
    end
  end

  // Timer 10: same countdown, with its own prescaler.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sec_10 <= L_SEC_10;
      r_sub_10 <= L_SUB_TOP;
    end else if (timer_reset_10) begin
      r_sec_10 <= L_SEC_10;
      r_sub_10 <= L_SUB_TOP;
    end else if (!hold && r_sec_10 != L_SEC_0) begin
      if (r_sub_10 == L_SUB_0) begin
        r_sub_10 <= L_SUB_TOP;
        r_sec_10 <= r_sec_10 - 1'b1;
      end else begin
        r_sub_10 <= r_sub_10 - 1'b1;
      end
    end
  end

  assign timer_done_60 = (r_sec_60 == L_SEC_0);
  assign timer_done_50 = (r_sec_50 == L_SEC_0);
  assign timer_done_10 = (r_sec_10 == L_SEC_0);

`ifdef TLC_REMAIN_OUT_EN
  typedef enum logic [1:0] {
    SEL_60 = 2'd0,
    SEL_50 = 2'd1,
    SEL_10 = 2'd2
  } sel_t;

  sel_t r_sel;

  // Track the most recently restarted timer; 60 > 50 > 10 when strobes coincide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sel <= SEL_60;
    end else if (timer_reset_60) begin
      r_sel <= SEL_60;
    end else if (timer_reset_50) begin
      r_sel <= SEL_50;
    end else if (timer_reset_10) begin
      r_sel <= SEL_10;
    end
  end

  // Display value follows the selected counter directly.
  always_comb begin
    remain_sec = r_sec_60;
    case (r_sel)
      SEL_50:  remain_sec = r_sec_50;
      SEL_10:  remain_sec = r_sec_10;
      default: remain_sec = r_sec_60;
    endcase
  end
`endif

endmodule

// File: tb/tb_traffic_timer_unit.sv
// Directed bench for traffic_timer_unit with TICK_DIV=4, T60=6, T50=5, T10=2.
// Expected expiry points are hand-computed edge counts, so the timers expire
// 24, 20 and 8 edges after a load. Inputs change 1 ns after a rising edge, and
// outputs are sampled at that same point.

module tb_traffic_timer_unit;

  localparam int SEC_W = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic hold = 1'b0;
  logic tr60 = 1'b0, tr50 = 1'b0, tr10 = 1'b0;
  logic d60, d50, d10;
`ifdef TLC_REMAIN_OUT_EN
  logic [SEC_W-1:0] remain;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  traffic_timer_unit #(
    .TICK_DIV(4), .T60(6), .T50(5), .T10(2), .SEC_W(SEC_W), .DIV_W(26)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .timer_reset_60 (tr60),
    .timer_reset_50 (tr50),
    .timer_reset_10 (tr10),
`ifdef TLC_REMAIN_OUT_EN
    .remain_sec     (remain),
`endif
    .timer_done_60  (d60),
    .timer_done_50  (d50),
    .timer_done_10  (d10)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_d60", d60, 0);
    chk("rst_d50", d50, 0);
    chk("rst_d10", d10, 0);
    reset = 1'b0;
`ifdef TLC_REMAIN_OUT_EN
    chk("rst_remain", remain, 6);
`endif

    // Free run after release: expiries at edges 8, 20 and 24
    step(7);  chk("init_d10_e7", d10, 0);
    step(1);  chk("init_d10_e8", d10, 1);
    chk("init_d50_e8", d50, 0);
    step(11); chk("init_d50_e19", d50, 0);
    step(1);  chk("init_d50_e20", d50, 1);
    step(3);  chk("init_d60_e23", d60, 0);
    step(1);  chk("init_d60_e24", d60, 1);
    step(3);  chk("init_d60_sticky", d60, 1);

    // Restart timer 10 while it is done
    tr10 = 1'b1; step(1); tr10 = 1'b0;
    chk("r10_low", d10, 0);
    chk("r10_d60_kept", d60, 1);
    chk("r10_d50_kept", d50, 1);
`ifdef TLC_REMAIN_OUT_EN
    chk("r10_remain", remain, 2);
`endif
    step(7);  chk("r10_e7", d10, 0);
    step(1);  chk("r10_e8", d10, 1);

    // Restart timer 50 again 10 edges into its count
    tr50 = 1'b1; step(1); tr50 = 1'b0;
    chk("r50_low", d50, 0);
    step(9);
    tr50 = 1'b1; step(1); tr50 = 1'b0;
    step(10); chk("r50_e20", d50, 0);
    step(9);  chk("r50_e29", d50, 0);
    step(1);  chk("r50_e30", d50, 1);

    // Hold timer 10 for edges k+3..k+5
    tr10 = 1'b1; step(1); tr10 = 1'b0;
    step(2); hold = 1'b1;
    step(3); hold = 1'b0;
    chk("hold_d60_frozen", d60, 1);
    step(5); chk("hold_e10", d10, 0);
    step(1); chk("hold_e11", d10, 1);

    // Simultaneous strobes with hold high: the strobes win
    tr60 = 1'b1; tr50 = 1'b1; tr10 = 1'b1; hold = 1'b1;
    step(1);
    tr60 = 1'b0; tr50 = 1'b0; tr10 = 1'b0; hold = 1'b0;
    chk("all_d60_low", d60, 0);
    chk("all_d50_low", d50, 0);
    chk("all_d10_low", d10, 0);
`ifdef TLC_REMAIN_OUT_EN
    chk("all_remain_prio", remain, 6);
`endif
    step(7);  chk("all_d10_e7", d10, 0);
    step(1);  chk("all_d10_e8", d10, 1);
    step(11); chk("all_d50_e19", d50, 0);
    step(1);  chk("all_d50_e20", d50, 1);
    step(3);  chk("all_d60_e23", d60, 0);
    step(1);  chk("all_d60_e24", d60, 1);

    // Asynchronous reset mid-count of timer 60
    tr60 = 1'b1; step(1); tr60 = 1'b0;
    step(5);
    #2 reset = 1'b1;
    #1;
    chk("arst_d60", d60, 0);
    chk("arst_d50", d50, 0);
    chk("arst_d10", d10, 0);
    step(2);
    reset = 1'b0;
`ifdef TLC_REMAIN_OUT_EN
    chk("arst_remain", remain, 6);
`endif
    step(23); chk("arst_d60_e23", d60, 0);
    step(1);  chk("arst_d60_e24", d60, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
